// File: rtl/vga_frame_capture.sv
// vga_frame_capture: captures one requested VGA frame into a frame-buffer write port and checks its geometry
module vga_frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 24
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              HS,
  input  logic              VS,
  input  logic              blank_n,
  input  logic [7:0]        r_data,
  input  logic [7:0]        g_data,
  input  logic [7:0]        b_data,
  input  logic              capture_req,
  output logic              capture_busy,
  output logic              capture_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [2:0]        err
);
  localparam logic [ADDR_W:0] PIX_N = (ADDR_W+1)'(H_ACTIVE*V_ACTIVE);
  localparam int HS_W = $clog2(2*H_ACTIVE+1);
  localparam logic [HS_W-1:0] HS_MAX = HS_W'(2*H_ACTIVE);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t state, state_nx;
  logic hs_q, vs_q, vs_p, bl_q, bl_p;
  logic [DATA_W-1:0] rgb_q;
  logic [10:0] col_cnt;
  logic [9:0] line_cnt;
  logic [ADDR_W:0] pix_cnt;
  logic [HS_W-1:0] hs_cnt;
  logic vs_fall, bl_fall, start, cap, pix_ok;
  assign vs_fall = vs_p & ~vs_q;
  assign bl_fall = bl_p & ~bl_q;
  assign start   = state == IDLE && capture_req;
  assign cap     = state == CAPTURE;
  assign pix_ok  = pix_cnt != PIX_N;
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b0;
      vs_p  <= 1'b0;
      bl_q  <= 1'b0;
      bl_p  <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= HS;
      vs_q  <= VS;
      vs_p  <= vs_q;
      bl_q  <= blank_n;
      bl_p  <= bl_q;
      rgb_q <= DATA_W'({r_data, g_data, b_data});
    end
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = capture_req ? ARMED : IDLE;
      ARMED:   state_nx = vs_fall ? CAPTURE : ARMED;
      CAPTURE: state_nx = vs_fall ? DONE : CAPTURE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    capture_busy = state == ARMED || state == CAPTURE;
    capture_done = state == DONE;
  end
  // counters saturate instead of wrapping; pixel writes stop at a full frame
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      err      <= '0;
      col_cnt  <= '0;
      line_cnt <= '0;
      pix_cnt  <= '0;
      hs_cnt   <= '0;
    end else begin
      wr_en <= cap && bl_q && pix_ok;
      if (start) begin
        err      <= '0;
        col_cnt  <= '0;
        line_cnt <= '0;
        pix_cnt  <= '0;
        hs_cnt   <= '0;
      end else if (cap) begin
        if (bl_q && pix_ok) begin
          wr_addr <= pix_cnt[ADDR_W-1:0];
          wr_data <= rgb_q;
          pix_cnt <= pix_cnt + 1'b1;
          col_cnt <= col_cnt + 11'(~&col_cnt);
        end
        if (bl_q && !pix_ok) err[2] <= 1'b1;
        if (bl_fall) begin
          if (col_cnt != 11'(H_ACTIVE)) err[0] <= 1'b1;
          line_cnt <= line_cnt + 10'(~&line_cnt);
          col_cnt  <= '0;
        end
        hs_cnt <= hs_q ? '0 : hs_cnt + HS_W'(hs_cnt != HS_MAX);
        if (!hs_q && hs_cnt == HS_MAX) err[1] <= 1'b1;
        if (vs_fall && (line_cnt != 10'(V_ACTIVE) || pix_ok || bl_q || bl_fall)) err[1] <= 1'b1;
      end
    end
endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: randomized frame streams checked against a per-frame arithmetic model
module tb_vga_frame_capture;
  localparam int H = 8, V = 4, AW = 5, N = H*V;
  logic vga_clk = 0, reset = 1, HS = 1, VS = 1, blank_n = 0, capture_req = 0;
  logic [7:0] r_data = 0, g_data = 0, b_data = 0;
  logic capture_busy, capture_done, wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0] wr_data;
  logic [2:0] err, err_done, e;
  int total = 0, bad = 0, done_cnt = 0, busy_lo = 0, nw;
  bit rec = 0, seq_data = 0;
  int lens[8];
  logic [AW-1:0] m_addr[$];
  logic [23:0] m_data[$], sent[$];

  vga_frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW), .DATA_W(24)) dut (
    .vga_clk(vga_clk), .reset(reset), .HS(HS), .VS(VS), .blank_n(blank_n),
    .r_data(r_data), .g_data(g_data), .b_data(b_data), .capture_req(capture_req),
    .capture_busy(capture_busy), .capture_done(capture_done), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .err(err));

  always #5 vga_clk = ~vga_clk;

  always @(negedge vga_clk) begin
    if (wr_en) begin m_addr.push_back(wr_addr); m_data.push_back(wr_data); end
    if (capture_done) begin done_cnt++; err_done = err; end
    if (rec && !capture_busy) busy_lo++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // expected writes are the first N active pixels; errors follow the line/frame rules
  task automatic model(input int nl, output logic [2:0] ex, output int nwr);
    int tot = 0;
    ex = 3'b000;
    for (int l = 0; l < nl; l++) begin
      int w = (tot >= N) ? 0 : ((lens[l] < N - tot) ? lens[l] : N - tot);
      if (w != H) ex[0] = 1'b1;
      tot += lens[l];
    end
    nwr = tot < N ? tot : N;
    ex[2] = tot > N;
    ex[1] = nl != V || nwr != N;
  endtask

  task automatic clear();
    m_addr.delete(); m_data.delete(); sent.delete();
    done_cnt = 0; busy_lo = 0; err_done = 3'bxxx;
  endtask

  task automatic set_lens(input int a, input int b, input int c, input int d, input int x);
    lens[0] = a; lens[1] = b; lens[2] = c; lens[3] = d; lens[4] = x;
  endtask

  task automatic pulse_req();
    @(negedge vga_clk) capture_req = 1;
    @(negedge vga_clk) capture_req = 0;
  endtask

  task automatic vs_pulse(input bit req);
    @(negedge vga_clk) begin VS = 0; blank_n = 0; end
    @(negedge vga_clk) capture_req = req;
    @(negedge vga_clk) begin capture_req = 0; VS = 1; end
    @(negedge vga_clk);
  endtask

  task automatic drive_lines(input int nl, input int req_line);
    int pix = 0;
    for (int l = 0; l < nl; l++) begin
      for (int p = 0; p < lens[l]; p++) begin
        logic [23:0] d;
        d = seq_data ? 24'(pix) : 24'($urandom);
        @(negedge vga_clk);
        blank_n = 1; HS = 1;
        {r_data, g_data, b_data} = d;
        capture_req = (l == req_line && p == 0);
        if (rec) sent.push_back(d);
        pix++;
      end
      @(negedge vga_clk) begin blank_n = 0; capture_req = 0; HS = 0; end
      @(negedge vga_clk);
      @(negedge vga_clk) HS = 1;
      @(negedge vga_clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge vga_clk);
    total++;
    if ({capture_busy, capture_done, wr_en, wr_addr, wr_data, err} !== '0) begin
      bad++; $display("FAIL reset_values got=%h exp=0", {capture_busy, capture_done, wr_en, wr_addr, wr_data, err});
    end
    reset = 0;
    repeat (3) @(negedge vga_clk);
  endtask

  task automatic test_nominal();
    clear(); seq_data = 1; set_lens(8, 8, 8, 8, 0);
    pulse_req();
    total++;
    if (capture_busy !== 1'b1) begin bad++; $display("FAIL nominal_busy_armed got=%b exp=1", capture_busy); end
    rec = 1; vs_pulse(0); drive_lines(4, -1); rec = 0; vs_pulse(0);
    repeat (3) @(negedge vga_clk);
    model(4, e, nw);
    total++;
    if (m_addr.size() !== nw) begin bad++; $display("FAIL nominal_count got=%0d exp=%0d", m_addr.size(), nw); end
    for (int i = 0; i < m_addr.size() && i < nw; i++) begin
      total++;
      if ({m_addr[i], m_data[i]} !== {AW'(i), 24'(i)}) begin
        bad++; $display("FAIL nominal_write%0d got=%h/%h exp=%h/%h", i, m_addr[i], m_data[i], AW'(i), 24'(i));
      end
    end
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL nominal_done got=%0d exp=1", done_cnt); end
    total++;
    if (err_done !== e) begin bad++; $display("FAIL nominal_err got=%b exp=%b", err_done, e); end
    total++;
    if (busy_lo !== 0 || capture_busy !== 1'b0) begin
      bad++; $display("FAIL nominal_busy got=%0d/%b exp=0/0", busy_lo, capture_busy);
    end
    seq_data = 0;
  endtask

  task automatic test_mid_frame();
    clear(); set_lens(8, 8, 8, 8, 0);
    vs_pulse(0); drive_lines(4, 1);
    total++;
    if (m_addr.size() !== 0 || capture_busy !== 1'b1) begin
      bad++; $display("FAIL midframe_early got=%0d/%b exp=0/1", m_addr.size(), capture_busy);
    end
    rec = 1; vs_pulse(0); drive_lines(4, -1); rec = 0; vs_pulse(0);
    repeat (3) @(negedge vga_clk);
    model(4, e, nw);
    total++;
    if (m_addr.size() !== nw) begin bad++; $display("FAIL midframe_count got=%0d exp=%0d", m_addr.size(), nw); end
    for (int i = 0; i < m_addr.size() && i < nw; i++) begin
      total++;
      if ({m_addr[i], m_data[i]} !== {AW'(i), sent[i]}) begin
        bad++; $display("FAIL midframe_write%0d got=%h/%h exp=%h/%h", i, m_addr[i], m_data[i], AW'(i), sent[i]);
      end
    end
    total++;
    if (busy_lo !== 0 || done_cnt !== 1 || err_done !== e) begin
      bad++; $display("FAIL midframe_status got=%0d/%0d/%b exp=0/1/%b", busy_lo, done_cnt, err_done, e);
    end
  endtask

  task automatic test_geometry(input int nl, input logic [2:0] req_err);
    clear();
    pulse_req();
    rec = 1; vs_pulse(0); drive_lines(nl, -1); rec = 0; vs_pulse(0);
    repeat (3) @(negedge vga_clk);
    model(nl, e, nw);
    total++;
    if (e !== req_err) begin bad++; $display("FAIL geom_model got=%b exp=%b", e, req_err); end
    total++;
    if (m_addr.size() !== nw) begin bad++; $display("FAIL geom_count got=%0d exp=%0d", m_addr.size(), nw); end
    for (int i = 0; i < m_addr.size() && i < nw; i++) begin
      total++;
      if ({m_addr[i], m_data[i]} !== {AW'(i), sent[i]}) begin
        bad++; $display("FAIL geom_write%0d got=%h/%h exp=%h/%h", i, m_addr[i], m_data[i], AW'(i), sent[i]);
      end
    end
    total++;
    if (done_cnt !== 1 || err_done !== e) begin
      bad++; $display("FAIL geom_err got=%0d/%b exp=1/%b", done_cnt, err_done, e);
    end
  endtask

  task automatic test_hs_stuck();
    clear(); set_lens(8, 8, 8, 8, 0);
    pulse_req();
    vs_pulse(0); drive_lines(4, -1);
    @(negedge vga_clk) HS = 0;
    repeat (2*H + 2) @(negedge vga_clk);
    HS = 1;
    vs_pulse(0);
    repeat (3) @(negedge vga_clk);
    total++;
    if (m_addr.size() !== N || err_done !== 3'b010) begin
      bad++; $display("FAIL hs_stuck got=%0d/%b exp=%0d/010", m_addr.size(), err_done, N);
    end
  endtask

  task automatic test_reset_mid();
    int n_rst = -1;
    clear(); set_lens(8, 8, 8, 8, 0);
    pulse_req();
    rec = 1; vs_pulse(0);
    fork
      drive_lines(4, -1);
      begin
        for (int i = 0; i < 200 && m_addr.size() < 11; i++) @(negedge vga_clk);
        total++;
        if (m_addr.size() < 11) begin
          bad++; $display("FAIL rstmid_timeout got=%0d exp=11", m_addr.size());
        end else begin
          #2 reset = 1;
          #1 n_rst = m_addr.size();
          if ({capture_busy, capture_done, wr_en, wr_addr, wr_data, err} !== '0) begin
            bad++; $display("FAIL rstmid_outputs got=%h exp=0", {capture_busy, capture_done, wr_en, wr_addr, wr_data, err});
          end
          @(negedge vga_clk) reset = 0;
        end
      end
    join
    rec = 0; vs_pulse(0);
    repeat (3) @(negedge vga_clk);
    for (int i = 0; i < 11 && i < m_addr.size(); i++) begin
      total++;
      if ({m_addr[i], m_data[i]} !== {AW'(i), sent[i]}) begin
        bad++; $display("FAIL rstmid_write%0d got=%h/%h exp=%h/%h", i, m_addr[i], m_data[i], AW'(i), sent[i]);
      end
    end
    total++;
    if (m_addr.size() !== n_rst || done_cnt !== 0) begin
      bad++; $display("FAIL rstmid_after got=%0d/%0d exp=%0d/0", m_addr.size(), done_cnt, n_rst);
    end
    test_geometry(4, 3'b000);
  endtask

  task automatic test_collision();
    clear(); set_lens(8, 8, 8, 8, 0);
    vs_pulse(1); drive_lines(4, -1);
    total++;
    if (m_addr.size() !== 0 || capture_busy !== 1'b1) begin
      bad++; $display("FAIL collision_ignored got=%0d/%b exp=0/1", m_addr.size(), capture_busy);
    end
    rec = 1; vs_pulse(0); drive_lines(4, 1); rec = 0; vs_pulse(0);
    repeat (3) @(negedge vga_clk);
    model(4, e, nw);
    total++;
    if (m_addr.size() !== nw || done_cnt !== 1 || err_done !== e) begin
      bad++; $display("FAIL collision_frame got=%0d/%0d/%b exp=%0d/1/%b", m_addr.size(), done_cnt, err_done, nw, e);
    end
    for (int i = 0; i < m_addr.size() && i < nw; i++) begin
      total++;
      if ({m_addr[i], m_data[i]} !== {AW'(i), sent[i]}) begin
        bad++; $display("FAIL collision_write%0d got=%h/%h exp=%h/%h", i, m_addr[i], m_data[i], AW'(i), sent[i]);
      end
    end
    clear();
    drive_lines(4, -1); vs_pulse(0); drive_lines(4, -1); vs_pulse(0);
    repeat (3) @(negedge vga_clk);
    total++;
    if (m_addr.size() !== 0 || done_cnt !== 0 || capture_busy !== 1'b0) begin
      bad++; $display("FAIL collision_not_queued got=%0d/%0d/%b exp=0/0/0", m_addr.size(), done_cnt, capture_busy);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mid_frame();
    set_lens(8, 8, 7, 8, 0);
    test_geometry(4, 3'b011);
    set_lens(8, 8, 8, 8, 8);
    test_geometry(5, 3'b111);
    test_hs_stuck();
    test_reset_mid();
    test_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_frame_capture.md
Name: vga_frame_capture

Overview:
- Receive-side counterpart of the VGA output path. Samples the outgoing VGA stream (HS, VS, blank_n, r/g/b) on the pixel clock.
- On request, captures exactly one full frame into a frame-buffer write port, one word per active pixel.
- Checks the stream's line length and line count against the configured geometry.
- Used for frame dump, self-check and loopback of the display pipeline.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- ADDR_W, 19, write-address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
- DATA_W, 24, pixel word width {r,g,b}

Ports:
- vga_clk  input  1  pixel clock; all logic on posedge
- reset  input  1  asynchronous, active-high reset
- HS  input  1  horizontal sync, active low
- VS  input  1  vertical sync, active low
- blank_n  input  1  1 = active pixel
- r_data  input  8  red
- g_data  input  8  green
- b_data  input  8  blue
- capture_req  input  1  single-cycle request to capture the next full frame
- capture_busy  output  1  high from the accepted request until done
- capture_done  output  1  one-cycle pulse at end of the captured frame
- wr_en  output  1  frame-buffer write strobe
- wr_addr  output  ADDR_W  linear pixel address, row-major from 0
- wr_data  output  DATA_W  {r_data,g_data,b_data}; r in [23:16], b in [7:0]
- err  output  3  sticky error flags, valid from capture_done until the next accepted request

Behaviour:
- Clock and reset: one clock (vga_clk); reset is asynchronous and active-high.
- Reset values: state=IDLE; capture_busy=0, capture_done=0, wr_en=0, wr_addr=0, wr_data=0, err=0.
- Internal counters cleared on reset.
- Input registering: HS, VS, blank_n and rgb are registered once. vs_fall = previous registered VS==1 and current registered VS==0. bl_fall is defined the same way on blank_n.
- States:
  - IDLE: capture_req=1 → ARMED. err, pixel counter, column counter and line counter are all cleared. A VS falling edge in the same cycle as the request is ignored.
  - ARMED: capture_busy=1; vs_fall → CAPTURE.
  - CAPTURE:
    - Each registered cycle with blank_n=1 and pix_cnt < H_ACTIVE*V_ACTIVE: wr_en=1, wr_addr=pix_cnt, wr_data=registered rgb, then pix_cnt++ and col_cnt++.
    - Latency: wr_en is asserted 2 vga_clk cycles after the pixel appears on the input pins (input register + output register).
    - Overflow: a pixel arriving with pix_cnt == H_ACTIVE*V_ACTIVE gets no write and sets err[2]. wr_addr never exceeds H_ACTIVE*V_ACTIVE-1.
    - On bl_fall: if col_cnt != H_ACTIVE, set err[0]. Then line_cnt++ and col_cnt=0.
    - On vs_fall (end of frame): if line_cnt != V_ACTIVE or pix_cnt != H_ACTIVE*V_ACTIVE, set err[1]. Then → DONE.
  - DONE: capture_done=1 for exactly one cycle, capture_busy=0, → IDLE.
- capture_req in ARMED, CAPTURE or DONE is ignored; it is not queued.
- When not writing: wr_en=0, and wr_addr/wr_data hold their last values.
- A line whose active region is still open at vs_fall is not counted and raises err[1].
- HS is monitored only for presence. HS low for more than 2*H_ACTIVE consecutive cycles in CAPTURE sets err[1].
- Reset asserted mid-capture: immediate return to IDLE with reset values. Partial writes already issued are not retracted.
- Counter widths: col_cnt 11 bits, line_cnt 10 bits, pix_cnt ADDR_W+1 bits. No wrap is permitted.

Test Plan:
- Sim geometry: H_ACTIVE=8, V_ACTIVE=4.
- Nominal frame: request in IDLE, stream of 4 lines × 8 pixels with rgb = address → wr_en pulses exactly 32 times, wr_addr 0..31 in order, wr_data=24'h000000..24'h00001F. capture_done pulses once on the second vs_fall; err=3'b000.
- Request mid-frame: capture_req while lines 1–2 are streaming → no writes until the next vs_fall. The following full frame is captured; capture_busy is high throughout.
- Short line: line 2 has 7 active pixels → err[0]=1 and err[1]=1 (pix_cnt=31) at capture_done; writes stop at wr_addr=30.
- Extra line: 5 lines of 8 → 32 writes only; 33rd pixel sets err[2]; err[1]=1.
- Reset mid-capture: assert reset after write 10 → all outputs 0 immediately. A new request afterwards captures cleanly from wr_addr=0.
- Collision: capture_req coincident with vs_fall in IDLE → that edge ignored, capture begins at the next vs_fall. A second capture_req during CAPTURE has no effect.
